// File: rtl/tc_capture_ctrl.sv
// ============================================================================
//  Module      : tc_capture_ctrl
//  Description : Acquisition sequencer for the time-compensated sample stream.
//                Per laser trigger: wait a programmable delay, then open a
//                capture window of gate_num gates x gate_len samples. Repeats
//                for pulse_num pulses, then reports frame completion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_capture_ctrl #(
    parameter int DELAY_W = 16,
    parameter int GLEN_W  = 10,
    parameter int GNUM_W  = 8,
    parameter int PNUM_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         trigger,
    input  logic               trigger_tc_ready,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [GLEN_W-1:0]  cfg_gate_len,
    input  logic [GNUM_W-1:0]  cfg_gate_num,
    input  logic [PNUM_W-1:0]  cfg_pulse_num,
    output logic               gate_en,
    output logic               gate_first,
    output logic               gate_last,
    output logic [GNUM_W-1:0]  gate_idx,
    output logic [PNUM_W-1:0]  pulse_idx,
    output logic               busy,
    output logic               frame_done,
    output logic               cfg_err,
    output logic [15:0]        missed_trig
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ARM   = 3'd1;
    localparam logic [2:0] c_DELAY = 3'd2;
    localparam logic [2:0] c_GATE  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [DELAY_W-1:0] c_DELAY_ONE = DELAY_W'(1);
    localparam logic [GLEN_W-1:0]  c_GLEN_ONE  = GLEN_W'(1);
    localparam logic [GNUM_W-1:0]  c_GNUM_ONE  = GNUM_W'(1);
    localparam logic [PNUM_W-1:0]  c_PNUM_ONE  = PNUM_W'(1);

    logic [2:0]         r_state;
    logic               r_trig_d;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] r_dcnt;
    logic [GLEN_W-1:0]  r_len_m1;
    logic [GNUM_W-1:0]  r_num_m1;
    logic [PNUM_W-1:0]  r_pnum_m1;
    logic [GLEN_W-1:0]  r_samp;

    logic               w_trig_edge;
    logic               w_cfg_ok;
    logic [GLEN_W-1:0]  w_samp_nxt;

    assign w_trig_edge = (|trigger) & ~r_trig_d;
    assign w_cfg_ok    = (cfg_gate_len != '0) && (cfg_gate_num != '0) &&
                         (cfg_pulse_num != '0);
    assign w_samp_nxt  = r_samp + c_GLEN_ONE;

    // Previous OR of the trigger bus, for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) r_trig_d <= 1'b0;
        else     r_trig_d <= |trigger;
    end

    // Sequencer: state, latched config, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_delay     <= '0;
            r_dcnt      <= '0;
            r_len_m1    <= '0;
            r_num_m1    <= '0;
            r_pnum_m1   <= '0;
            r_samp      <= '0;
            gate_en     <= 1'b0;
            gate_first  <= 1'b0;
            gate_last   <= 1'b0;
            gate_idx    <= '0;
            pulse_idx   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            cfg_err     <= 1'b0;
            missed_trig <= '0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;

            // A trigger during an open acquisition is dropped but counted
            if (w_trig_edge && (r_state == c_DELAY || r_state == c_GATE) &&
                missed_trig != 16'hFFFF)
                missed_trig <= missed_trig + 16'd1;

            if (r_state == c_IDLE) begin
                if (start) begin
                    if (w_cfg_ok) begin
                        r_delay     <= cfg_delay;
                        r_len_m1    <= cfg_gate_len - c_GLEN_ONE;
                        r_num_m1    <= cfg_gate_num - c_GNUM_ONE;
                        r_pnum_m1   <= cfg_pulse_num - c_PNUM_ONE;
                        pulse_idx   <= '0;
                        gate_idx    <= '0;
                        missed_trig <= '0;
                        busy        <= 1'b1;
                        r_state     <= c_ARM;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end
            end else if (abort) begin
                // Abort drops the window immediately; counters keep their values
                r_state    <= c_IDLE;
                busy       <= 1'b0;
                gate_en    <= 1'b0;
                gate_first <= 1'b0;
                gate_last  <= 1'b0;
            end else begin
                case (r_state)
                    c_ARM: begin
                        if (w_trig_edge && trigger_tc_ready) begin
                            if (r_delay == '0) begin
                                r_state    <= c_GATE;
                                r_samp     <= '0;
                                gate_en    <= 1'b1;
                                gate_first <= 1'b1;
                                gate_last  <= (r_len_m1 == '0);
                            end else begin
                                r_dcnt  <= r_delay - c_DELAY_ONE;
                                r_state <= c_DELAY;
                            end
                        end
                    end
                    c_DELAY: begin
                        if (r_dcnt == '0) begin
                            r_state    <= c_GATE;
                            r_samp     <= '0;
                            gate_en    <= 1'b1;
                            gate_first <= 1'b1;
                            gate_last  <= (r_len_m1 == '0);
                        end else begin
                            r_dcnt <= r_dcnt - c_DELAY_ONE;
                        end
                    end
                    c_GATE: begin
                        if (r_samp == r_len_m1) begin
                            if (gate_idx == r_num_m1) begin
                                // Window complete for this pulse
                                gate_en    <= 1'b0;
                                gate_first <= 1'b0;
                                gate_last  <= 1'b0;
                                if (pulse_idx == r_pnum_m1) begin
                                    r_state    <= c_DONE;
                                    frame_done <= 1'b1;
                                end else begin
                                    pulse_idx <= pulse_idx + c_PNUM_ONE;
                                    gate_idx  <= '0;
                                    r_state   <= c_ARM;
                                end
                            end else begin
                                gate_idx   <= gate_idx + c_GNUM_ONE;
                                r_samp     <= '0;
                                gate_first <= 1'b1;
                                gate_last  <= (r_len_m1 == '0);
                            end
                        end else begin
                            r_samp     <= w_samp_nxt;
                            gate_first <= 1'b0;
                            gate_last  <= (w_samp_nxt == r_len_m1);
                        end
                    end
                    c_DONE: begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/tc_capture_ctrl.md
# tc_capture_ctrl

Acquisition sequencer for the delayed sample stream (x0_i/x0z_i pair) produced by the time-compensation FIFO. On each laser trigger it waits a programmable delay, then opens a capture window of `gate_num` range gates of `gate_len` samples each. It repeats this for `pulse_num` pulses, then reports frame completion. Its outputs gate the downstream FFT/accumulation path, and it counts triggers that arrive while a window is already in progress.

## Interface
- `DELAY_W`, 16: width of the trigger-to-window delay.
- `GLEN_W`, 10: width of the samples-per-gate field.
- `GNUM_W`, 8: width of the gates-per-pulse field.
- `PNUM_W`, 16: width of the pulses-per-frame field.

- `clk`  in  1  sample clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `trigger`  in  4  laser trigger bus; event = rising edge of the OR of all bits.
- `trigger_tc_ready`  in  1  delay FIFO is producing valid data.
- `start`  in  1  one-cycle pulse; starts a frame.
- `abort`  in  1  one-cycle pulse; terminates the frame.
- `cfg_delay`  in  DELAY_W  cycles from trigger to first gated sample.
- `cfg_gate_len`  in  GLEN_W  samples per gate; must be nonzero.
- `cfg_gate_num`  in  GNUM_W  gates per pulse; must be nonzero.
- `cfg_pulse_num`  in  PNUM_W  pulses per frame; must be nonzero.
- `gate_en`  out  1  current sample is inside a capture window.
- `gate_first`  out  1  first sample of a gate.
- `gate_last`  out  1  last sample of a gate.
- `gate_idx`  out  GNUM_W  index of the current gate, starting at 0.
- `pulse_idx`  out  PNUM_W  index of the current pulse, starting at 0.
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of the frame.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.
- `missed_trig`  out  16  count of triggers dropped during DELAY or GATE; saturates at 0xFFFF.

## Operation
- Trigger edge detection:
  - A registered copy `trig_d` holds the previous `|trigger`.
  - `trig_edge` = `|trigger & ~trig_d`.
  - `trig_d` resets to 0.
- States: IDLE, ARM, DELAY, GATE, DONE.
- IDLE:
  - On `start` with all three size fields nonzero: latch the entire cfg bus, clear `pulse_idx` and `missed_trig`, go to ARM.
  - On `start` with any size field zero: pulse `cfg_err` and stay in IDLE.
  - cfg changes outside IDLE have no effect.
- ARM:
  - `trig_edge` with `trigger_tc_ready`=1 → DELAY, or → GATE directly if the latched delay is 0.
  - `trig_edge` with `trigger_tc_ready`=0 is ignored and not counted.
- DELAY: counts `cfg_delay` cycles, then → GATE.
- GATE:
  - `gate_en`=1 throughout.
  - Sample counter runs 0..gate_len-1, then wraps to 0 and increments `gate_idx`.
  - `gate_first` is high when the sample counter is 0; `gate_last` is high when it is gate_len-1. Both are high together when gate_len=1.
  - After the last sample of gate gate_num-1:
    - If `pulse_idx` = pulse_num-1 → DONE.
    - Otherwise `pulse_idx`+1, `gate_idx` cleared, → ARM.
- DONE: `frame_done`=1 for one cycle, then → IDLE. `pulse_idx` holds its final value.
- `trig_edge` in DELAY or GATE increments `missed_trig` (saturating). The trigger does not restart the window.
- `abort` in any non-IDLE state:
  - → IDLE on the next cycle.
  - `gate_en`, `gate_first` and `gate_last` drop on that same cycle.
  - No `frame_done` is issued.
  - Counters hold their values.
- `abort` and `start` in the same cycle while IDLE: `start` wins.
- `abort` and frame end in the same cycle: `abort` wins, so `frame_done` is suppressed.
- Reset: state IDLE; all outputs 0, including `missed_trig`, `gate_idx` and `pulse_idx`.

## Timing
- All outputs are registered.
- Window position: if `trig_edge` is true in cycle T, the first `gate_en` cycle is T+1+cfg_delay.
- Window length: `gate_en` stays high for exactly gate_len×gate_num contiguous cycles per pulse.
- ARM re-entry: the cycle after the last gated sample is in ARM. A `trig_edge` in that cycle is accepted.
- `frame_done` is asserted in the cycle after the final gated sample.
- `busy` rises the cycle after an accepted `start` and falls the cycle after DONE or after `abort`.
- `cfg_err` is asserted the cycle after the rejected `start`.
- `gate_idx` changes in the same cycle that `gate_first` is asserted.

## Test plan
- Basic frame:
  - Stimulus: delay=5, len=4, num=3, pulses=2; `start`; trigger edges at cycles 10 and 40.
  - Required: `gate_en` high during cycles 16–27 and 46–57.
  - Required: `gate_first` at 16, 20, 24 (and the same offsets for the second pulse); `gate_idx` 0,1,2.
  - Required: `frame_done` at cycle 58; `busy` low at cycle 59.
- Zero delay and len=1:
  - Stimulus: delay=0, len=1, num=2, pulses=1; trigger edge at T.
  - Required: `gate_en` in cycles T+1 and T+2, with `gate_first`=`gate_last`=1 in both.
- Missed triggers and ready gating:
  - Stimulus: extra trigger edges during DELAY and during GATE.
  - Required: `missed_trig`=2 and window timing unchanged.
  - Stimulus: trigger edge in ARM with `trigger_tc_ready`=0.
  - Required: no window opens and the count does not change.
- Held trigger: `trigger`=4'b0101 held high for 20 cycles produces exactly one accepted event.
- Config error: `start` with gate_num=0 → `cfg_err` pulses once, `busy` stays 0, state remains IDLE.
- Abort:
  - Stimulus: `abort` in the 3rd gated cycle.
  - Required: `gate_en` low on the next cycle and IDLE; no `frame_done`.
  - Stimulus: `rst` mid-GATE.
  - Required: all outputs 0 on the next cycle.
